// File: rtl/mem_line_responder_pkg.sv
// Shared types and size helpers for the line-granular memory responder.
package mem_line_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWbWait,
    StWbCommit,
    StRdWait,
    StResp
  } state_e;

  localparam int unsigned STATS_WIDTH   = 16;
  localparam int unsigned LAT_CNT_WIDTH = 16;

  function automatic int unsigned line_size_bits(input int unsigned line_bytes);
    return 8 * line_bytes;
  endfunction

  function automatic int unsigned mem_index_bits(input int unsigned mem_lines);
    return $clog2(mem_lines);
  endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// Cache-to-memory miss/evict bus. Stats ports appear only with MEM_LINE_STATS_EN defined.
interface mem_line_responder_if
  import mem_line_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned LINE_SIZE_BITS = 512
);
  logic                      i_cache_miss;
  logic [ADDRESS_WIDTH-1:0]  i_addr;
  logic                      i_evict;
  logic [ADDRESS_WIDTH-1:0]  i_evict_addr;
  logic [LINE_SIZE_BITS-1:0] i_evict_data;
  logic [LINE_SIZE_BITS-1:0] o_memory_line;
  logic                      o_memory_response;
  logic                      o_evict_ack;
  logic                      o_busy;
`ifdef MEM_LINE_STATS_EN
  logic [STATS_WIDTH-1:0]    o_fill_count;
  logic [STATS_WIDTH-1:0]    o_wb_count;

  modport master (
    output i_cache_miss, i_addr, i_evict, i_evict_addr, i_evict_data,
    input  o_memory_line, o_memory_response, o_evict_ack, o_busy, o_fill_count, o_wb_count
  );
  modport slave (
    input  i_cache_miss, i_addr, i_evict, i_evict_addr, i_evict_data,
    output o_memory_line, o_memory_response, o_evict_ack, o_busy, o_fill_count, o_wb_count
  );
`else
  modport master (
    output i_cache_miss, i_addr, i_evict, i_evict_addr, i_evict_data,
    input  o_memory_line, o_memory_response, o_evict_ack, o_busy
  );
  modport slave (
    input  i_cache_miss, i_addr, i_evict, i_evict_addr, i_evict_data,
    output o_memory_line, o_memory_response, o_evict_ack, o_busy
  );
`endif
endinterface

// File: rtl/mem_line_responder_latency_counter.sv
// Loadable down-counter that parks at zero; zero flag ends a latency wait.
module latency_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_line_responder.sv
// Line-granular backing store answering cache fills and writebacks after fixed latencies.
// Optional fill/writeback counters are enabled by defining MEM_LINE_STATS_EN.
module mem_line_responder
  import mem_line_pkg::*;
#(
  parameter int unsigned LINE_SIZE_BYTES = 64,
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned OFFSET_BITS     = 6,
  parameter int unsigned MEM_LINES       = 1024,
  parameter int unsigned READ_LATENCY    = 4,
  parameter int unsigned WRITE_LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_line_responder_if.slave  bus
);

  localparam int unsigned LineBits = line_size_bits(LINE_SIZE_BYTES);
  localparam int unsigned IdxBits  = mem_index_bits(MEM_LINES);

  state_e                   state_q, state_d;
  logic [IdxBits-1:0]       idx_q;
  logic [LineBits-1:0]      wdata_q;
  logic [LineBits-1:0]      line_q;
  logic [LineBits-1:0]      mem [0:MEM_LINES-1];

  logic                     cnt_load;
  logic [LAT_CNT_WIDTH-1:0] cnt_val;
  logic                     cnt_zero;
  logic                     accept_wb;
  logic                     accept_rd;

  // Upper address bits alias onto the store and offset bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr, bus.i_evict_addr};

  latency_counter #(
    .WIDTH(LAT_CNT_WIDTH)
  ) u_latency_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    accept_wb = 1'b0;
    accept_rd = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Evict wins so a fill to the same line observes the written data.
        if (bus.i_evict) begin
          state_d   = StWbWait;
          cnt_load  = 1'b1;
          cnt_val   = LAT_CNT_WIDTH'(WRITE_LATENCY - 1);
          accept_wb = 1'b1;
        end else if (bus.i_cache_miss) begin
          state_d   = StRdWait;
          cnt_load  = 1'b1;
          cnt_val   = LAT_CNT_WIDTH'(READ_LATENCY - 1);
          accept_rd = 1'b1;
        end
      end
      StWbWait:   if (cnt_zero) state_d = StWbCommit;
      StWbCommit: state_d = StIdle;
      StRdWait:   if (cnt_zero) state_d = StResp;
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wdata_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept_wb) begin
        idx_q   <= bus.i_evict_addr[OFFSET_BITS +: IdxBits];
        wdata_q <= bus.i_evict_data;
      end else if (accept_rd) begin
        idx_q   <= bus.i_addr[OFFSET_BITS +: IdxBits];
      end
      // Read on the last wait cycle so the line is registered during StResp.
      if (state_q == StRdWait && cnt_zero) begin
        line_q <= mem[idx_q];
      end
    end
  end

  // Store is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (state_q == StWbCommit) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.o_memory_line     = line_q;
  assign bus.o_memory_response = (state_q == StResp);
  assign bus.o_evict_ack       = (state_q == StWbCommit);
  assign bus.o_busy            = (state_q != StIdle);

`ifdef MEM_LINE_STATS_EN
  logic [STATS_WIDTH-1:0] fill_cnt_q;
  logic [STATS_WIDTH-1:0] wb_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == StResp && fill_cnt_q != '1) fill_cnt_q <= fill_cnt_q + 1'b1;
      if (state_q == StWbCommit && wb_cnt_q != '1) wb_cnt_q <= wb_cnt_q + 1'b1;
    end
  end

  assign bus.o_fill_count = fill_cnt_q;
  assign bus.o_wb_count   = wb_cnt_q;
`endif

endmodule
